// File: rtl/sync_tx_pkg.sv
// Shared types and constants for the sync-word frame transmitter.
package sync_tx_pkg;

    localparam int unsigned       WORD_W            = 10;
    localparam logic [WORD_W-1:0] DEFAULT_SYNC_WORD = 10'b1111100110;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        PAYLOAD
    } tx_state_t;

endpackage

// File: rtl/sync_frame_transmitter_word_shifter.sv
// Parallel-load, MSB-first word shifter shared by the sync word and payload words.
module word_shifter
    import sync_tx_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    output logic              next_msb
);

    logic [WORD_W-1:0] word_q;

    // Rotating rather than zero-filling leaves the word intact after a full pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
        end else if (load) begin
            word_q <= load_data;
        end else if (shift) begin
            word_q <= {word_q[WORD_W-2:0], word_q[WORD_W-1]};
        end
    end

    assign next_msb = word_q[WORD_W-2];

endmodule

// File: rtl/sync_frame_transmitter.sv
// Serial frame transmitter: preamble, sync word, then a fixed count of payload words, MSB-first.
module sync_frame_transmitter
    import sync_tx_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
    parameter int unsigned       PREAMBLE_BITS = 8,
    parameter int unsigned       PAYLOAD_WORDS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_tick,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done,
    output logic              underrun
);

    localparam int unsigned BIT_MAX    = (PREAMBLE_BITS > WORD_W) ? PREAMBLE_BITS : WORD_W;
    localparam int unsigned BIT_CNT_W  = $clog2(BIT_MAX + 1);
    localparam int unsigned WORD_CNT_W = $clog2(PAYLOAD_WORDS + 1);

    localparam logic [BIT_CNT_W-1:0]  PRE_LAST  = BIT_CNT_W'(PREAMBLE_BITS);
    localparam logic [BIT_CNT_W-1:0]  WORD_LAST = BIT_CNT_W'(WORD_W);
    localparam logic [WORD_CNT_W-1:0] WORDS_MAX = WORD_CNT_W'(PAYLOAD_WORDS);

    tx_state_t             state_q, state_n;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_n;
    logic [WORD_CNT_W-1:0] words_acc_q, words_acc_n;
    logic [WORD_CNT_W-1:0] words_sent_q, words_sent_n;
    logic [WORD_W-1:0]     hold_q, hold_n;
    logic                  hold_full_q, hold_full_n;
    logic                  tx_bit_n, tx_active_n, frame_done_n, underrun_n;

    logic                  accept;
    logic                  end_frame;
    logic                  shift_load, shift_en;
    logic [WORD_W-1:0]     shift_data;
    logic                  next_msb;

    assign in_ready = !hold_full_q && (words_acc_q < WORDS_MAX) && !reset;
    assign accept   = in_valid && in_ready;

    word_shifter u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (shift_load),
        .shift    (shift_en),
        .load_data(shift_data),
        .next_msb (next_msb)
    );

    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        words_acc_n  = words_acc_q;
        words_sent_n = words_sent_q;
        hold_n       = hold_q;
        hold_full_n  = hold_full_q;
        tx_bit_n     = tx_bit;
        tx_active_n  = tx_active;
        frame_done_n = 1'b0;
        underrun_n   = 1'b0;
        end_frame    = 1'b0;
        shift_load   = 1'b0;
        shift_en     = 1'b0;
        shift_data   = SYNC_WORD;

        if (accept) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
            words_acc_n = words_acc_q + WORD_CNT_W'(1);
        end

        // hold_full_q is the pre-edge value, so the tick of the acceptance cycle cannot start a frame.
        if (bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        state_n     = PREAMBLE;
                        tx_bit_n    = 1'b1;
                        tx_active_n = 1'b1;
                        bit_cnt_n   = BIT_CNT_W'(1);
                    end
                end
                PREAMBLE: begin
                    if (bit_cnt_q < PRE_LAST) begin
                        tx_bit_n  = !tx_bit;
                        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
                    end else begin
                        state_n    = SYNC;
                        shift_load = 1'b1;
                        shift_data = SYNC_WORD;
                        tx_bit_n   = SYNC_WORD[WORD_W-1];
                        bit_cnt_n  = BIT_CNT_W'(1);
                    end
                end
                SYNC, PAYLOAD: begin
                    if (bit_cnt_q < WORD_LAST) begin
                        shift_en  = 1'b1;
                        tx_bit_n  = next_msb;
                        bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
                    end else if (words_sent_q == WORDS_MAX) begin
                        frame_done_n = 1'b1;
                        end_frame    = 1'b1;
                    end else if (hold_full_q) begin
                        state_n      = PAYLOAD;
                        shift_load   = 1'b1;
                        shift_data   = hold_q;
                        tx_bit_n     = hold_q[WORD_W-1];
                        bit_cnt_n    = BIT_CNT_W'(1);
                        words_sent_n = words_sent_q + WORD_CNT_W'(1);
                        hold_full_n  = 1'b0;
                    end else begin
                        underrun_n = 1'b1;
                        end_frame  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // A word accepted on the closing edge belongs to the next frame.
        if (end_frame) begin
            state_n      = IDLE;
            tx_bit_n     = 1'b0;
            tx_active_n  = 1'b0;
            bit_cnt_n    = '0;
            words_sent_n = '0;
            words_acc_n  = WORD_CNT_W'(accept);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            words_acc_q  <= '0;
            words_sent_q <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            tx_bit       <= 1'b0;
            tx_active    <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_q      <= state_n;
            bit_cnt_q    <= bit_cnt_n;
            words_acc_q  <= words_acc_n;
            words_sent_q <= words_sent_n;
            hold_q       <= hold_n;
            hold_full_q  <= hold_full_n;
            tx_bit       <= tx_bit_n;
            tx_active    <= tx_active_n;
            frame_done   <= frame_done_n;
            underrun     <= underrun_n;
        end
    end

endmodule

// File: tb/tb_sync_frame_transmitter.sv
// Directed bench for sync_frame_transmitter with PREAMBLE_BITS=4, PAYLOAD_WORDS=2.
module tb_sync_frame_transmitter;

    localparam logic [9:0]  SYNC   = 10'b1111100110;
    localparam logic [33:0] FRAME1 = {4'b1010, SYNC, 10'h2AB, 10'h155};
    localparam logic [33:0] FRAME2 = {4'b1010, SYNC, 10'h0F0, 10'h30C};
    localparam logic [23:0] SHORT1 = {4'b1010, SYNC, 10'h2AB};

    logic       clk = 1'b0;
    logic       reset, bit_tick, in_valid;
    logic [9:0] in_data;
    logic       in_ready, tx_bit, tx_active, frame_done, underrun;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          tick_div = 1;
    int          cyc      = 0;
    int          n_accepted = 0;
    bit          acc;
    logic [9:0]  feed_q[$];

    logic [9:0]  corr_sr;
    int          sync_idx, sync_hits, done_pulses, under_pulses;

    sync_frame_transmitter #(
        .SYNC_WORD    (10'b1111100110),
        .PREAMBLE_BITS(4),
        .PAYLOAD_WORDS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_tick  (bit_tick),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_bit    (tx_bit),
        .tx_active (tx_active),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_active(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_active === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    // First sample is the one already taken after tx_active rose.
    task automatic collect(input int n, output logic [63:0] bits);
        bits = '0;
        corr_sr = '0;
        sync_idx = -1; sync_hits = 0; done_pulses = 0; under_pulses = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            bits    = {bits[62:0], tx_bit};
            corr_sr = {corr_sr[8:0], tx_bit};
            if (10 - $countones(corr_sr ^ SYNC) == 10) begin
                sync_hits++;
                sync_idx = k;
            end
            if (frame_done === 1'b1) done_pulses++;
            if (underrun === 1'b1) under_pulses++;
        end
    endtask

    initial begin
        bit_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bit_tick = ((cyc % tick_div) == 0);
        end
    end

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #2;
            if (acc && feed_q.size() > 0) begin
                feed_q.delete(0);
                n_accepted++;
            end
            if (feed_q.size() > 0) begin
                in_valid = 1'b1;
                in_data  = feed_q[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] bits;
        int errs, rdy_errs, quiet;

        reset = 1'b1;
        repeat (3) step();
        check("rst_tx_bit", tx_bit, 1'b0);
        check("rst_tx_active", tx_active, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        step();
        check("idle_in_ready", in_ready, 1'b1);

        // 1 + 2: full frame and correlator position
        feed_q = '{10'h2AB, 10'h155};
        wait_active("t1_start");
        collect(34, bits);
        check("t1_frame", bits, {30'b0, FRAME1});
        check("t1_no_early_done", done_pulses, 0);
        check("t2_sync_idx", sync_idx, 13);
        check("t2_sync_hits", sync_hits, 1);
        step();
        check("t1_frame_done", frame_done, 1'b1);
        check("t1_tx_bit_idle", tx_bit, 1'b0);
        check("t1_tx_active_idle", tx_active, 1'b0);
        step();
        check("t1_done_one_cycle", frame_done, 1'b0);

        // 3: underrun at the second payload boundary
        feed_q = '{10'h2AB};
        wait_active("t3_start");
        collect(24, bits);
        check("t3_prefix", bits, {40'b0, SHORT1});
        check("t3_no_early_underrun", under_pulses, 0);
        step();
        check("t3_underrun", underrun, 1'b1);
        check("t3_tx_active", tx_active, 1'b0);
        check("t3_tx_bit", tx_bit, 1'b0);
        check("t3_in_ready", in_ready, 1'b1);
        check("t3_no_done", frame_done, 1'b0);
        step();
        check("t3_underrun_one_cycle", underrun, 1'b0);

        // 4: slow ticks, in_valid held high
        tick_div = 4;
        n_accepted = 0;
        feed_q = '{10'h2AB, 10'h155, 10'h3FF};
        wait_active("t4_start");
        errs = 0; rdy_errs = 0;
        for (int k = 0; k < 136; k++) begin
            if (k > 0) step();
            if (tx_bit !== FRAME1[33 - k/4]) errs++;
            if (n_accepted >= 2 && in_ready !== 1'b0) rdy_errs++;
        end
        check("t4_bit_periods", errs, 0);
        check("t4_ready_held_low", rdy_errs, 0);
        step();
        check("t4_frame_done", frame_done, 1'b1);
        check("t4_accepted", n_accepted, 2);
        check("t4_ready_in_idle", in_ready, 1'b1);
        reset = 1'b1;
        feed_q.delete();
        tick_div = 1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // 5: reset during SYNC_WORD[5]
        feed_q = '{10'h2AB, 10'h155};
        wait_active("t5_start");
        collect(9, bits);
        check("t5_prefix", bits, 64'b1010_11111);
        reset = 1'b1;
        feed_q.delete();
        step();
        check("t5_tx_bit", tx_bit, 1'b0);
        check("t5_tx_active", tx_active, 1'b0);
        check("t5_in_ready_in_reset", in_ready, 1'b0);
        check("t5_no_pulses", {frame_done, underrun}, 2'b00);
        reset = 1'b0;
        step();
        check("t5_in_ready", in_ready, 1'b1);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (frame_done !== 1'b0 || underrun !== 1'b0 || tx_active !== 1'b0) quiet++;
        end
        check("t5_stays_idle", quiet, 0);

        // 6: next frame's first word offered in the frame_done cycle
        feed_q = '{10'h2AB, 10'h155, 10'h0F0, 10'h30C};
        wait_active("t6_start");
        collect(34, bits);
        check("t6_frame1", bits, {30'b0, FRAME1});
        step();
        check("t6_frame_done", frame_done, 1'b1);
        check("t6_ready_in_done", in_ready, 1'b1);
        step();
        check("t6_accept_cycle_idle", tx_active, 1'b0);
        step();
        check("t6_restart_active", tx_active, 1'b1);
        check("t6_restart_bit", tx_bit, 1'b1);
        collect(34, bits);
        check("t6_frame2", bits, {30'b0, FRAME2});
        step();
        check("t6_frame2_done", frame_done, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
